// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: funct3 codes, FSM states, access sizing helpers.
// Pure declarations; no timing or flow-control behaviour of its own.
package lsu_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_RMW_READ,
    S_GAP,
    S_WRITE,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } size_t;

  // Undefined funct3 codes fall through to word width.
  function automatic size_t f3_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return SZ_BYTE;
      F3_H, F3_HU: return SZ_HALF;
      F3_W:        return SZ_WORD;
      default:     return SZ_WORD;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lane);
    case (f3_size(f3))
      SZ_HALF: return lane[0];
      SZ_WORD: return lane != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] align_lane(input logic [2:0] f3, input logic [1:0] lane);
    case (f3_size(f3))
      SZ_HALF: return {lane[1], 1'b0};
      SZ_WORD: return 2'b00;
      default: return lane;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: load extract/extend and sub-word store merge into a cache word.
// Zero latency, no flow control.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      lane,
  input  logic [XLEN-1:0] word,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data,
  output logic [XLEN-1:0] store_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel   = word[{lane, 3'b000} +: 8];
    half_sel   = word[{lane[1], 4'b0000} +: 16];
    load_data  = word;
    store_word = word;

    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data = {24'h0, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data = {16'h0, half_sel};
      default: load_data = word;
    endcase

    case (f3_size(funct3))
      SZ_BYTE: store_word[{lane, 3'b000} +: 8]     = wdata[7:0];
      SZ_HALF: store_word[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      default: store_word = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit ahead of a strobe-less data cache; sub-word stores use read-modify-write.
// LW hit 2 cycles, SB/SH hit 5; busy holds off new requests. LSU_MISALIGN_TRAP_EN selects trap vs force-align.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int RESET_PC_UNUSED = 0,
  parameter int ADDR_WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  lsu_req,
  input  logic                  lsu_we,
  input  logic [2:0]            lsu_funct3,
  input  logic [ADDR_WIDTH-1:0] lsu_addr,
  input  logic [XLEN-1:0]       lsu_wdata,
  output logic                  lsu_busy,
  output logic                  lsu_done,
  output logic [XLEN-1:0]       lsu_rdata,
  output logic                  lsu_misaligned,
  output logic                  cache_read_request,
  output logic                  cache_write_request,
  output logic [ADDR_WIDTH-1:0] cache_addr,
  output logic [XLEN-1:0]       cache_write_data,
  input  logic                  cache_response,
  input  logic [XLEN-1:0]       cache_read_data
);

  // Reserved parameter; at its required value of 0 the latched address resets to 0.
  localparam logic [ADDR_WIDTH-1:0] ADDR_RST = ADDR_WIDTH'(RESET_PC_UNUSED);

  state_t                state_q, state_d, start_state;
  logic                  accept;
  logic [1:0]            req_lane;
  logic [2:0]            f3_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [XLEN-1:0]       load_data, store_word;

`ifdef LSU_MISALIGN_TRAP_EN
  logic req_mis, mis_q;
  assign req_mis  = is_misaligned(lsu_funct3, lsu_addr[1:0]);
  assign req_lane = lsu_addr[1:0];
`else
  assign req_lane = align_lane(lsu_funct3, lsu_addr[1:0]);
`endif

  assign accept     = lsu_req && (state_q == S_IDLE || state_q == S_DONE);
  assign cache_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    start_state = S_READ;
    if (lsu_we) start_state = (f3_size(lsu_funct3) == SZ_WORD) ? S_WRITE : S_RMW_READ;
`ifdef LSU_MISALIGN_TRAP_EN
    if (req_mis) start_state = S_DONE;
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: state_d = lsu_req ? start_state : S_IDLE;
      S_READ:         if (cache_response) state_d = S_DONE;
      S_RMW_READ:     if (cache_response) state_d = S_GAP;
      S_GAP:          state_d = S_WRITE;
      S_WRITE:        if (cache_response) state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  // Outputs decode the registered state only, so requests never follow lsu_req combinationally.
  always_comb begin
    lsu_busy            = (state_q == S_READ) || (state_q == S_RMW_READ) ||
                          (state_q == S_GAP)  || (state_q == S_WRITE);
    lsu_done            = (state_q == S_DONE);
    cache_read_request  = (state_q == S_READ) || (state_q == S_RMW_READ);
    cache_write_request = (state_q == S_WRITE);
`ifdef LSU_MISALIGN_TRAP_EN
    lsu_misaligned      = (state_q == S_DONE) && mis_q;
`else
    lsu_misaligned      = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f3_q             <= '0;
      addr_q           <= ADDR_RST;
      cache_write_data <= '0;
      lsu_rdata        <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      mis_q            <= 1'b0;
`endif
    end else begin
      // cache_write_data carries the raw store data until an RMW read replaces it with the merge.
      if (accept) begin
        f3_q             <= lsu_funct3;
        addr_q           <= {lsu_addr[ADDR_WIDTH-1:2], req_lane};
        cache_write_data <= lsu_wdata;
`ifdef LSU_MISALIGN_TRAP_EN
        mis_q            <= req_mis;
`endif
      end
      if (state_q == S_READ && cache_response)     lsu_rdata        <= load_data;
      if (state_q == S_RMW_READ && cache_response) cache_write_data <= store_word;
    end
  end

  lsu_lane_align u_lane_align (
    .funct3     (f3_q),
    .lane       (addr_q[1:0]),
    .word       (cache_read_data),
    .wdata      (cache_write_data),
    .load_data  (load_data),
    .store_word (store_word)
  );

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small latency-programmable cache model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lsu_req, lsu_we;
  logic [2:0]  lsu_funct3;
  logic [31:0] lsu_addr, lsu_wdata;
  logic        lsu_busy, lsu_done, lsu_misaligned;
  logic [31:0] lsu_rdata;
  logic        cache_read_request, cache_write_request, cache_response;
  logic [31:0] cache_addr, cache_write_data, cache_read_data;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] rd_word = 32'h0;
  int rd_lat = 0;
  int wr_lat = 1;
  int req_cyc = 0;

  int done_cnt, mis_cnt, rd_cycles, wr_cycles, wr_rises, wr_unstable, overlap_cnt, gap_cycles;
  logic [31:0] last_rd_addr, last_wr_addr, last_wr_data;
  logic prev_wr = 1'b0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .lsu_req             (lsu_req),
    .lsu_we              (lsu_we),
    .lsu_funct3          (lsu_funct3),
    .lsu_addr            (lsu_addr),
    .lsu_wdata           (lsu_wdata),
    .lsu_busy            (lsu_busy),
    .lsu_done            (lsu_done),
    .lsu_rdata           (lsu_rdata),
    .lsu_misaligned      (lsu_misaligned),
    .cache_read_request  (cache_read_request),
    .cache_write_request (cache_write_request),
    .cache_addr          (cache_addr),
    .cache_write_data    (cache_write_data),
    .cache_response      (cache_response),
    .cache_read_data     (cache_read_data)
  );

  // Cache model: response once a request has been held for the programmed number of cycles.
  always @(posedge clk) begin
    if (cache_read_request || cache_write_request) req_cyc <= req_cyc + 1;
    else req_cyc <= 0;
  end
  assign cache_response  = (cache_read_request && req_cyc >= rd_lat) ||
                           (cache_write_request && req_cyc >= wr_lat);
  assign cache_read_data = rd_word;

  always @(negedge clk) begin
    if (cache_read_request && cache_write_request) overlap_cnt++;
    if (lsu_busy && !cache_read_request && !cache_write_request) gap_cycles++;
    if (lsu_done) done_cnt++;
    if (lsu_misaligned) mis_cnt++;
    if (cache_read_request) begin
      rd_cycles++;
      last_rd_addr = cache_addr;
    end
    if (cache_write_request) begin
      if (wr_cycles > 0 && (cache_write_data !== last_wr_data || cache_addr !== last_wr_addr))
        wr_unstable++;
      if (!prev_wr) wr_rises++;
      wr_cycles++;
      last_wr_addr = cache_addr;
      last_wr_data = cache_write_data;
    end
    prev_wr = cache_write_request;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_mon();
    done_cnt = 0; mis_cnt = 0; rd_cycles = 0; wr_cycles = 0; wr_rises = 0;
    wr_unstable = 0; overlap_cnt = 0; gap_cycles = 0;
    last_rd_addr = 32'hX; last_wr_addr = 32'hX; last_wr_data = 32'hX;
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    lsu_req = 1'b1; lsu_we = we; lsu_funct3 = f3; lsu_addr = a; lsu_wdata = wd;
    tick();
    lsu_req = 1'b0;
  endtask

  // Returns cycles from the request cycle to the done cycle, or -1 on timeout.
  task automatic wait_done(input int start, output int cyc);
    cyc = start;
    while (!lsu_done && cyc < 60) begin
      tick();
      cyc++;
    end
    if (!lsu_done) cyc = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    vectors++; if (lsu_busy !== 1'b0 || lsu_done !== 1'b0 || lsu_misaligned !== 1'b0) begin miscompares++; $display("FAIL reset_status: busy=%b done=%b mis=%b want 000", lsu_busy, lsu_done, lsu_misaligned); end
    vectors++; if (cache_read_request !== 1'b0 || cache_write_request !== 1'b0) begin miscompares++; $display("FAIL reset_req: rd=%b wr=%b want 00", cache_read_request, cache_write_request); end
    vectors++; if (lsu_rdata !== 32'h0 || cache_addr !== 32'h0 || cache_write_data !== 32'h0) begin miscompares++; $display("FAIL reset_data: rdata=%h addr=%h wdata=%h want 0", lsu_rdata, cache_addr, cache_write_data); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_lw_hit();
    int cyc;
    clr_mon(); rd_word = 32'hDEADBEEF; rd_lat = 0;
    issue(1'b0, 3'b010, 32'h100, 32'h0);
    wait_done(1, cyc);
    vectors++; if (cyc !== 2) begin miscompares++; $display("FAIL lw_latency: got %0d want 2", cyc); end
    vectors++; if (lsu_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL lw_rdata: got %h want deadbeef", lsu_rdata); end
    tick(); tick();
    vectors++; if (wr_cycles !== 0 || done_cnt !== 1) begin miscompares++; $display("FAIL lw_side: wr_cycles=%0d done_cnt=%0d want 0/1", wr_cycles, done_cnt); end
    vectors++; if (last_rd_addr !== 32'h100) begin miscompares++; $display("FAIL lw_addr: got %h want 00000100", last_rd_addr); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    clr_mon(); rd_word = 32'h80AA55CC;
    issue(1'b0, 3'b000, 32'h103, 32'h0);
    wait_done(1, cyc);
    vectors++; if (cyc !== 2 || lsu_rdata !== 32'hFFFFFF80) begin miscompares++; $display("FAIL lb_rdata: cyc=%0d rdata=%h want 2/ffffff80", cyc, lsu_rdata); end
    vectors++; if (lsu_busy !== 1'b0) begin miscompares++; $display("FAIL done_busy: got %b want 0", lsu_busy); end
    issue(1'b0, 3'b100, 32'h103, 32'h0);
    vectors++; if (lsu_rdata !== 32'hFFFFFF80 || lsu_busy !== 1'b1) begin miscompares++; $display("FAIL b2b_hold: rdata=%h busy=%b want ffffff80/1", lsu_rdata, lsu_busy); end
    wait_done(1, cyc);
    vectors++; if (cyc !== 2 || lsu_rdata !== 32'h00000080) begin miscompares++; $display("FAIL lbu_rdata: cyc=%0d rdata=%h want 2/00000080", cyc, lsu_rdata); end
    tick(); tick();
    vectors++; if (done_cnt !== 2) begin miscompares++; $display("FAIL b2b_done_cnt: got %0d want 2", done_cnt); end
  endtask

  task automatic test_lhu_and_unknown();
    int cyc;
    clr_mon(); rd_word = 32'h8001700D;
    issue(1'b0, 3'b101, 32'h102, 32'h0);
    wait_done(1, cyc);
    vectors++; if (lsu_rdata !== 32'h00008001) begin miscompares++; $display("FAIL lhu_rdata: got %h want 00008001", lsu_rdata); end
    tick();
    rd_word = 32'hCAFEF00D;
    issue(1'b0, 3'b111, 32'h108, 32'h0);
    wait_done(1, cyc);
    vectors++; if (cyc !== 2 || lsu_rdata !== 32'hCAFEF00D) begin miscompares++; $display("FAIL unk_f3_rdata: cyc=%0d rdata=%h want 2/cafef00d", cyc, lsu_rdata); end
    tick();
  endtask

  task automatic test_sb_rmw();
    int cyc;
    clr_mon(); rd_word = 32'h11223344; rd_lat = 0; wr_lat = 1;
    issue(1'b1, 3'b000, 32'h102, 32'h00000012);
    wait_done(1, cyc);
    vectors++; if (cyc !== 5) begin miscompares++; $display("FAIL sb_latency: got %0d want 5", cyc); end
    tick(); tick();
    vectors++; if (last_wr_data !== 32'h11123344 || last_wr_addr !== 32'h100) begin miscompares++; $display("FAIL sb_write: data=%h addr=%h want 11123344/00000100", last_wr_data, last_wr_addr); end
    vectors++; if (overlap_cnt !== 0 || gap_cycles !== 1) begin miscompares++; $display("FAIL sb_gap: overlap=%0d gap=%0d want 0/1", overlap_cnt, gap_cycles); end
    vectors++; if (rd_cycles !== 1 || wr_cycles !== 2 || done_cnt !== 1) begin miscompares++; $display("FAIL sb_shape: rd=%0d wr=%0d done=%0d want 1/2/1", rd_cycles, wr_cycles, done_cnt); end
  endtask

  task automatic test_lh_misaligned();
    int cyc;
    clr_mon(); rd_word = 32'h8001700D;
    issue(1'b0, 3'b001, 32'h101, 32'h0);
    wait_done(1, cyc);
`ifdef LSU_MISALIGN_TRAP_EN
    vectors++; if (cyc !== 1 || lsu_misaligned !== 1'b1) begin miscompares++; $display("FAIL lh_trap_pulse: cyc=%0d mis=%b want 1/1", cyc, lsu_misaligned); end
    vectors++; if (lsu_rdata !== 32'hCAFEF00D) begin miscompares++; $display("FAIL lh_trap_rdata: got %h want cafef00d", lsu_rdata); end
    tick(); tick();
    vectors++; if (rd_cycles !== 0 || wr_cycles !== 0 || mis_cnt !== 1) begin miscompares++; $display("FAIL lh_trap_side: rd=%0d wr=%0d mis=%0d want 0/0/1", rd_cycles, wr_cycles, mis_cnt); end
`else
    vectors++; if (cyc !== 2 || lsu_misaligned !== 1'b0) begin miscompares++; $display("FAIL lh_align_done: cyc=%0d mis=%b want 2/0", cyc, lsu_misaligned); end
    vectors++; if (lsu_rdata !== 32'h0000700D) begin miscompares++; $display("FAIL lh_align_rdata: got %h want 0000700d", lsu_rdata); end
    tick(); tick();
    vectors++; if (last_rd_addr !== 32'h100 || mis_cnt !== 0) begin miscompares++; $display("FAIL lh_align_addr: addr=%h mis=%0d want 00000100/0", last_rd_addr, mis_cnt); end
`endif
  endtask

  task automatic test_sw_miss();
    int cyc;
    clr_mon(); wr_lat = 6;
    issue(1'b1, 3'b010, 32'h200, 32'hA5A55A5A);
    // A request while busy must be dropped.
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_funct3 = 3'b010; lsu_addr = 32'h300;
    tick();
    lsu_req = 1'b0;
    wait_done(2, cyc);
    vectors++; if (cyc !== 8) begin miscompares++; $display("FAIL sw_latency: got %0d want 8", cyc); end
    tick(); tick(); tick();
    vectors++; if (wr_cycles !== 7 || wr_rises !== 1 || wr_unstable !== 0) begin miscompares++; $display("FAIL sw_hold: cycles=%0d rises=%0d unstable=%0d want 7/1/0", wr_cycles, wr_rises, wr_unstable); end
    vectors++; if (last_wr_addr !== 32'h200 || last_wr_data !== 32'hA5A55A5A) begin miscompares++; $display("FAIL sw_data: addr=%h data=%h want 00000200/a5a55a5a", last_wr_addr, last_wr_data); end
    vectors++; if (done_cnt !== 1 || rd_cycles !== 0) begin miscompares++; $display("FAIL sw_single: done=%0d rd=%0d want 1/0", done_cnt, rd_cycles); end
    wr_lat = 1;
  endtask

  task automatic test_reset_mid_read();
    int cyc;
    clr_mon(); rd_lat = 20;
    issue(1'b0, 3'b010, 32'h300, 32'h0);
    tick();
    vectors++; if (cache_read_request !== 1'b1 || lsu_busy !== 1'b1) begin miscompares++; $display("FAIL mid_read_active: rd=%b busy=%b want 1/1", cache_read_request, lsu_busy); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (cache_read_request !== 1'b0 || cache_write_request !== 1'b0 || lsu_busy !== 1'b0 || lsu_done !== 1'b0) begin miscompares++; $display("FAIL async_reset_ctl: rd=%b wr=%b busy=%b done=%b want 0000", cache_read_request, cache_write_request, lsu_busy, lsu_done); end
    vectors++; if (lsu_rdata !== 32'h0 || cache_addr !== 32'h0 || cache_write_data !== 32'h0) begin miscompares++; $display("FAIL async_reset_data: rdata=%h addr=%h wdata=%h want 0", lsu_rdata, cache_addr, cache_write_data); end
    tick();
    vectors++; if (cache_read_request !== 1'b0) begin miscompares++; $display("FAIL reset_held_req: got %b want 0", cache_read_request); end
    rst_n = 1'b1; rd_lat = 0; rd_word = 32'h0BADF00D;
    tick();
    clr_mon();
    issue(1'b0, 3'b010, 32'h104, 32'h0);
    wait_done(1, cyc);
    vectors++; if (cyc !== 2 || lsu_rdata !== 32'h0BADF00D) begin miscompares++; $display("FAIL post_reset_lw: cyc=%0d rdata=%h want 2/0badf00d", cyc, lsu_rdata); end
    vectors++; if (last_rd_addr !== 32'h104) begin miscompares++; $display("FAIL post_reset_addr: got %h want 00000104", last_rd_addr); end
  endtask

  initial begin
    rst_n = 1'b0; lsu_req = 1'b0; lsu_we = 1'b0; lsu_funct3 = 3'b0; lsu_addr = 32'h0; lsu_wdata = 32'h0;
    clr_mon();
    #1;
    test_reset();
    test_lw_hit();
    test_back_to_back();
    test_lhu_and_unknown();
    test_sb_rmw();
    test_lh_misaligned();
    test_sw_miss();
    test_reset_mid_read();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-stage load/store unit that sits directly upstream of the data cache.
- Accepts RV32I load/store requests from the execute/memory pipeline stage, keyed by funct3 and a byte address.
- Converts each request into word-aligned, full-word cache read/write handshakes. The cache has no byte strobes, so sub-word stores use a read-modify-write sequence.
- Extracts and sign/zero-extends load data, and returns a one-cycle completion pulse to the core.

Parameters:
- RESET_PC_UNUSED, 0, reserved; must remain 0.
- ADDR_WIDTH, 32, byte address width; cache address is always {addr[ADDR_WIDTH-1:2], 2'b00}.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- lsu_req  in  1  one-cycle request strobe; accepted only when busy=0
- lsu_we  in  1  1=store, 0=load
- lsu_funct3  in  3  LB=000 LH=001 LW=010 LBU=100 LHU=101 (loads); SB=000 SH=001 SW=010 (stores)
- lsu_addr  in  32  byte address
- lsu_wdata  in  32  store data (low byte/half used for SB/SH)
- lsu_busy  out  1  high from acceptance until the done pulse
- lsu_done  out  1  one-cycle completion pulse
- lsu_rdata  out  32  extended load result; valid while lsu_done=1, held until the next load completes
- lsu_misaligned  out  1  one-cycle pulse with lsu_done when the access was misaligned
- cache_read_request  out  1  to cache read_request
- cache_write_request  out  1  to cache write_request
- cache_addr  out  32  word-aligned address
- cache_write_data  out  32  full word to write
- cache_response  in  1  cache completion (combinational on a read hit, registered otherwise)
- cache_read_data  in  32  cache word

Behaviour:
- Reset (async, rst_n=0): state=IDLE; every output is 0, including lsu_rdata. A reset mid-operation drops cache requests immediately. The cache sees no further request.
- FSM states:
  - IDLE: on lsu_req, latch we/funct3/addr/wdata and assert busy. Next state:
    - loads → READ
    - SW → WRITE
    - SB/SH → RMW_READ
    - misaligned → DONE (behaviour per the optional feature)
  - READ: hold cache_read_request=1 and cache_addr until cache_response=1. On the response cycle:
    - register the extended data
    - drop the request the next cycle
    - go to DONE
  - RMW_READ: same handshake as READ. On response, register the merged word and go to WRITE, with a mandatory one-cycle gap in which both requests are 0.
  - WRITE: hold cache_write_request=1, cache_write_data and cache_addr until cache_response=1, then go to DONE.
  - DONE: lsu_done=1 and busy=0 for one cycle. A lsu_req in this cycle is accepted, so back-to-back operation is supported. Return to IDLE or the next state.
- Request rules:
  - cache_read_request and cache_write_request are never both 1.
  - Requests are registered outputs, never combinational from lsu_req.
  - lsu_req while busy=1 is ignored.
- Load extraction uses lane=addr[1:0]:
  - LB/LBU: byte [lane*8 +: 8], sign/zero extended.
  - LH/LHU: half [addr[1]*16 +: 16], extended.
  - LW: full word.
- Store merge:
  - SB replaces byte lane with wdata[7:0].
  - SH replaces half addr[1] with wdata[15:0].
  - All other bits come from the RMW read word.
- Misaligned definition: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]≠00. Byte accesses are never misaligned.
- Latency: LW hit = 2 cycles from lsu_req to lsu_done. Misses add the cache miss latency. SB/SH hit = 5 cycles (RMW_READ, gap, WRITE, plus the write-through latency).
- Unknown funct3 (011, 110, 111): treated as LW/SW width, with no extension.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN
- Defined: a misaligned request makes no cache access. Next cycle is DONE with lsu_misaligned=1 and lsu_rdata unchanged; the store has no side effect.
- Undefined: lsu_misaligned is tied 0. The address is forced to natural alignment (clear addr[0] for half; clear addr[1:0] for word) and the access proceeds normally.

Decomposition:
- Shared package lsu_pkg:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - state encoding (S_IDLE, S_READ, S_RMW_READ, S_GAP, S_WRITE, S_DONE)
  - width localparams
- One natural sub-module: lsu_lane_align. It is purely combinational: extract/extend for loads and merge for stores, with inputs funct3, addr[1:0], word, and wdata. The FSM stays in load_store_unit.

Test Plan:
- LW 0x100, cache hit (response same cycle as request, read_data=0xDEADBEEF) → lsu_done exactly 2 cycles after lsu_req, lsu_rdata=0xDEADBEEF, no write request.
- LB 0x103 and LBU 0x103, word 0x80AA55CC → rdata 0xFFFFFF80 and 0x00000080.
- SB 0x102 wdata 0x12, RMW read word 0x11223344 → cache_write_data=0x11123344 at addr 0x100; read and write requests never overlap; idle gap cycle observed.
- LH 0x101 → with LSU_MISALIGN_TRAP_EN: no cache request, lsu_done and lsu_misaligned pulse together. Without the macro: read at 0x100, upper-half extraction not used, rdata from half 0.
- Miss with cache_response delayed 6 cycles during SW 0x200 → cache_write_request held constant throughout, single lsu_done pulse.
- Assert rst_n=0 mid-READ → requests drop asynchronously, all outputs 0. After release, a new LW completes normally.
